// File: rtl/health_uplink_tx_pkg.sv
// rtl/health_uplink_tx_pkg.sv - shared mission constants and tx state enum for the health uplink
package health_uplink_tx_pkg;

    // Task FSM state codes as seen on state_enc
    localparam logic [2:0] FSM_IDLE     = 3'd0;
    localparam logic [2:0] FSM_TRANSMIT = 3'd3;

    // Packet framing
    localparam int         PKT_LEN        = 4;
    localparam logic [1:0] LAST_IDX       = 2'(PKT_LEN - 1);
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_RETRY,
        TX_DONE
    } tx_state_t;

    // Checksum byte: XOR of header, sequence number and zero-extended health
    function automatic logic [7:0] pkt_checksum(input logic [7:0] hdr,
                                                input logic [7:0] seq,
                                                input logic [1:0] health);
        return hdr ^ seq ^ {6'b0, health};
    endfunction

endpackage

// File: rtl/health_uplink_tx_stall_timer.sv
// rtl/health_uplink_tx_stall_timer.sv - consecutive-stall counter for one in-flight byte
module stall_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0]  LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Expiry is reported on the stalled cycle that finds the count already at its limit
    assign expired = enable && (count == LIMIT);

    // Count stalled cycles; saturate at the limit, any clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/health_uplink_tx.sv
// rtl/health_uplink_tx.sv - serialises a 4-byte health packet to the radio on TRANSMIT entry
module health_uplink_tx
    import health_uplink_tx_pkg::*;
#(
    parameter logic [7:0] HEADER         = DEFAULT_HEADER,
    parameter int         TIMEOUT_CYCLES = 256,
    parameter int         MAX_RETRIES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state_enc,
    input  logic [1:0] health_status,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       transmission_complete,
    output logic       busy,
    output logic       tx_error,
    output logic [7:0] seq_num
);

    localparam int            RW          = $clog2(MAX_RETRIES + 2);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    tx_state_t     state, next_state;
    logic [2:0]    prev_state_enc;
    logic          prev_valid;
    logic [1:0]    idx, next_idx;
    logic [7:0]    pkt_seq;
    logic [1:0]    pkt_health;
    logic [RW-1:0] retry_cnt;
    logic [7:0]    next_byte;
    logic          trigger, abort, hs;
    logic          stall_clear, stall_en, stall_expired;

    // prev_valid masks the first edge after reset so a level held through reset is not an entry
    assign trigger     = prev_valid && (state_enc == FSM_TRANSMIT) && (prev_state_enc != FSM_TRANSMIT);
    assign abort       = (state_enc != FSM_TRANSMIT);
    assign hs          = tx_valid && tx_ready;
    assign stall_en    = (state == TX_SEND) && tx_valid && !tx_ready;
    assign stall_clear = (state != TX_SEND) || hs;
    assign busy        = (state != TX_IDLE);

    stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (stall_clear),
        .enable  (stall_en),
        .expired (stall_expired)
    );

    // Next state and byte index; final-byte handshake outranks abort, abort outranks timeout
    always_comb begin
        next_state = state;
        next_idx   = idx;
        case (state)
            TX_IDLE: begin
                if (trigger) begin
                    next_state = TX_SEND;
                    next_idx   = 2'd0;
                end
            end
            TX_SEND: begin
                if (hs && (idx == LAST_IDX)) begin
                    next_state = TX_DONE;
                end else if (abort) begin
                    next_state = TX_IDLE;
                end else if (hs) begin
                    next_idx = idx + 2'd1;
                end else if (stall_expired) begin
                    next_state = (retry_cnt < RETRY_LIMIT) ? TX_RETRY : TX_DONE;
                end
            end
            TX_RETRY: begin
                next_idx   = 2'd0;
                next_state = abort ? TX_IDLE : TX_SEND;
            end
            TX_DONE: begin
                next_state = TX_IDLE;
            end
            default: begin
                next_state = TX_IDLE;
            end
        endcase
    end

    // Byte mux; index 0 is the header constant, so packet registers need not be captured yet
    always_comb begin
        next_byte = HEADER;
        case (next_idx)
            2'd0:    next_byte = HEADER;
            2'd1:    next_byte = pkt_seq;
            2'd2:    next_byte = {6'b0, pkt_health};
            default: next_byte = pkt_checksum(HEADER, pkt_seq, pkt_health);
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Track the task FSM encoding for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state_enc <= FSM_IDLE;
            prev_valid     <= 1'b0;
        end else begin
            prev_state_enc <= state_enc;
            prev_valid     <= 1'b1;
        end
    end

    // Packet context, retry bookkeeping, sticky error and sequence number
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= 2'd0;
            pkt_seq    <= 8'h00;
            pkt_health <= 2'b00;
            retry_cnt  <= '0;
            tx_error   <= 1'b0;
            seq_num    <= 8'h00;
        end else begin
            idx <= next_idx;
            if ((state == TX_IDLE) && trigger) begin
                pkt_seq    <= seq_num;
                pkt_health <= health_status;
                retry_cnt  <= '0;
                tx_error   <= 1'b0;
            end
            if (state == TX_RETRY) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            // Leaving SEND for DONE without a handshake means the retries ran out
            if ((state == TX_SEND) && (next_state == TX_DONE) && !hs) begin
                tx_error <= 1'b1;
            end
            if ((state == TX_DONE) && !tx_error) begin
                seq_num <= seq_num + 8'd1;
            end
        end
    end

    // Registered link outputs and completion pulse, driven from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid              <= 1'b0;
            tx_data               <= 8'h00;
            transmission_complete <= 1'b0;
        end else begin
            tx_valid              <= (next_state == TX_SEND);
            tx_data               <= (next_state == TX_SEND) ? next_byte : 8'h00;
            transmission_complete <= (next_state == TX_DONE);
        end
    end

endmodule

// File: tb/tb_health_uplink_tx.sv
// tb/tb_health_uplink_tx.sv - directed self-checking bench for health_uplink_tx
module tb_health_uplink_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state_enc;
    logic [1:0] health_status;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       transmission_complete;
    logic       busy;
    logic       tx_error;
    logic [7:0] seq_num;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    health_uplink_tx #(
        .HEADER         (8'hA5),
        .TIMEOUT_CYCLES (4),
        .MAX_RETRIES    (2)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .state_enc             (state_enc),
        .health_status         (health_status),
        .tx_ready              (tx_ready),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .transmission_complete (transmission_complete),
        .busy                  (busy),
        .tx_error              (tx_error),
        .seq_num               (seq_num)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_packet(input logic [1:0] h, input logic [7:0] s);
        logic [7:0] nxt;
        nxt = s + 8'd1;
        state_enc = 3'd0; health_status = h; tx_ready = 1'b1; tick();
        state_enc = 3'd3; tick();
        check("wrap_valid", tx_valid, 1);
        check("wrap_b0", tx_data, 8'hA5); tick();
        check("wrap_b1", tx_data, s); tick();
        check("wrap_b2", tx_data, {6'b0, h}); tick();
        check("wrap_b3", tx_data, 8'hA5 ^ s ^ {6'b0, h}); tick();
        check("wrap_done", transmission_complete, 1); tick();
        check("wrap_pulse_end", transmission_complete, 0);
        check("wrap_seq", seq_num, nxt);
    endtask

    initial begin
        rst = 1'b1; state_enc = 3'd0; health_status = 2'b10; tx_ready = 1'b1;
        #1;
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_seq", seq_num, 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();

        // Basic packet, health 2, back-to-back; later health change must not leak in
        state_enc = 3'd3; tick();
        health_status = 2'b00;
        check("t1_valid", tx_valid, 1);
        check("t1_busy", busy, 1);
        check("t1_b0", tx_data, 8'hA5); tick();
        check("t1_b1", tx_data, 8'h00); tick();
        check("t1_b2", tx_data, 8'h02); tick();
        check("t1_b3", tx_data, 8'hA7); tick();
        check("t1_pulse", transmission_complete, 1);
        check("t1_valid_low", tx_valid, 0); tick();
        check("t1_pulse_end", transmission_complete, 0);
        check("t1_seq", seq_num, 8'h01);
        check("t1_busy_end", busy, 0);

        // 255 more packets: seq 1..255, last carries FF with checksum 5A^health, then wraps
        for (int i = 1; i < 256; i++) begin
            run_packet(2'(i), 8'(i));
        end
        check("wrap_seq_zero", seq_num, 8'h00);

        // Three stall cycles on byte 1, health 1
        state_enc = 3'd0; health_status = 2'b01; tx_ready = 1'b1; tick();
        state_enc = 3'd3; tick();
        check("st_b0", tx_data, 8'hA5); tick();
        check("st_b1", tx_data, 8'h00);
        tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("st_hold_valid", tx_valid, 1);
            check("st_hold_data", tx_data, 8'h00);
        end
        tx_ready = 1'b1; tick();
        check("st_b2", tx_data, 8'h01); tick();
        check("st_b3", tx_data, 8'hA4); tick();
        check("st_pulse", transmission_complete, 1);
        check("st_err", tx_error, 0); tick();
        check("st_seq", seq_num, 8'h01);

        // Radio stuck: three attempts of four stalled cycles, then give up
        state_enc = 3'd0; tick();
        tx_ready = 1'b0; state_enc = 3'd3; tick();
        for (int a = 0; a < 3; a++) begin
            for (int k = 0; k < 4; k++) begin
                check("to_valid", tx_valid, 1);
                check("to_data", tx_data, 8'hA5);
                tick();
            end
            if (a < 2) begin
                check("to_retry_valid", tx_valid, 0);
                check("to_retry_pulse", transmission_complete, 0);
                check("to_retry_busy", busy, 1);
            end else begin
                check("to_pulse", transmission_complete, 1);
                check("to_err", tx_error, 1);
            end
            tick();
        end
        check("to_pulse_end", transmission_complete, 0);
        check("to_seq", seq_num, 8'h01);
        check("to_err_sticky", tx_error, 1);
        state_enc = 3'd0; tick();
        tx_ready = 1'b1; state_enc = 3'd3; tick();
        check("to_err_clear", tx_error, 0);
        check("to_re_b0", tx_data, 8'hA5); tick();
        check("to_re_b1", tx_data, 8'h01); tick(); tick(); tick();
        check("to_re_pulse", transmission_complete, 1); tick();
        check("to_re_seq", seq_num, 8'h02);

        // Abort during byte 2, then re-entry resends with the same sequence number
        state_enc = 3'd0; health_status = 2'b11; tick();
        state_enc = 3'd3; tick();
        check("ab_b0", tx_data, 8'hA5); tick();
        check("ab_b1", tx_data, 8'h02); tick();
        check("ab_b2", tx_data, 8'h03);
        state_enc = 3'd1; tick();
        check("ab_valid", tx_valid, 0);
        check("ab_busy", busy, 0);
        check("ab_pulse", transmission_complete, 0); tick();
        check("ab_pulse2", transmission_complete, 0);
        check("ab_seq", seq_num, 8'h02);
        state_enc = 3'd3; tick();
        check("ab_re_b0", tx_data, 8'hA5); tick();
        check("ab_re_b1", tx_data, 8'h02); tick(); tick();
        check("ab_re_b3", tx_data, 8'hA4); tick();
        check("ab_re_pulse", transmission_complete, 1); tick();
        check("ab_re_seq", seq_num, 8'h03);

        // Reset in the middle of byte 1 clears outputs without waiting for a clock edge
        state_enc = 3'd0; health_status = 2'b01; tick();
        state_enc = 3'd3; tick();
        check("rs_b0", tx_data, 8'hA5); tick();
        check("rs_b1", tx_data, 8'h03);
        #2 rst = 1'b1;
        #1;
        check("rs_valid", tx_valid, 0);
        check("rs_data", tx_data, 0);
        check("rs_busy", busy, 0);
        check("rs_pulse", transmission_complete, 0);
        check("rs_err", tx_error, 0);
        check("rs_seq", seq_num, 0);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rs_no_trig_valid", tx_valid, 0);
            check("rs_no_trig_busy", busy, 0);
        end
        state_enc = 3'd0; tick();
        state_enc = 3'd3; tick();
        check("rs_re_b0", tx_data, 8'hA5); tick();
        check("rs_re_b1", tx_data, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
